// File: rtl/rom_wb_fetch.sv
// rom_wb_fetch: Wishbone classic read-only slave fronting a synchronous 32-bit ROM.
// Define ROM_WB_FETCH_PREFETCH_EN to enable sequential next-word prefetch.
module rom_wb_fetch #(
  parameter  int ROM_SIZE  = 1024,
  localparam int ADDR_BITS = $clog2(ROM_SIZE / 4)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          wb_adr,
  input  logic                 wb_cyc,
  input  logic                 wb_stb,
  input  logic                 wb_we,
  output logic [31:0]          wb_rdt,
  output logic                 wb_ack,
  output logic [ADDR_BITS-1:0] rom_addr,
  output logic                 rom_ce,
  input  logic [31:0]          rom_data
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          rdt_q, rdt_d;
  logic                 ce;
  logic                 req;
  logic                 in_range;
  logic [ADDR_BITS-1:0] idx;
  logic                 unused_adr;

  assign req        = wb_cyc & wb_stb;
  assign idx        = wb_adr[ADDR_BITS+1:2];
  assign in_range   = (wb_adr[31:ADDR_BITS+2] == '0);
  assign unused_adr = ^wb_adr[1:0];

`ifdef ROM_WB_FETCH_PREFETCH_EN
  logic [ADDR_BITS-1:0] pf_idx_q, pf_idx_d;
  logic [ADDR_BITS-1:0] rd_idx_q, rd_idx_d;
  logic                 pf_valid_q, pf_valid_d;
  logic                 rd_rom_q, rd_rom_d;
  logic                 hit;

  assign hit = pf_valid_q & (idx == pf_idx_q);
`endif

  always_comb begin
    state_d  = state_q;
    rdt_d    = rdt_q;
    ce       = 1'b0;
    rom_addr = idx;
`ifdef ROM_WB_FETCH_PREFETCH_EN
    pf_idx_d   = pf_idx_q;
    pf_valid_d = pf_valid_q;
    rd_idx_d   = rd_idx_q;
    rd_rom_d   = rd_rom_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (wb_we | ~in_range) begin
            rdt_d   = '0;
            state_d = ACK;
`ifdef ROM_WB_FETCH_PREFETCH_EN
            rd_rom_d = 1'b0;
          end else if (hit) begin
            rdt_d      = rom_data;
            pf_valid_d = 1'b0;
            rd_idx_d   = idx;
            rd_rom_d   = 1'b1;
            state_d    = ACK;
`endif
          end else begin
            ce      = 1'b1;
            state_d = WAIT;
`ifdef ROM_WB_FETCH_PREFETCH_EN
            pf_valid_d = 1'b0;
            rd_idx_d   = idx;
            rd_rom_d   = 1'b1;
`endif
          end
        end
      end
      WAIT: begin
        if (wb_cyc) begin
          rdt_d   = rom_data;
          state_d = ACK;
        end else begin
          state_d = IDLE;
`ifdef ROM_WB_FETCH_PREFETCH_EN
          pf_valid_d = 1'b0;
`endif
        end
      end
      ACK: begin
        state_d = IDLE;
`ifdef ROM_WB_FETCH_PREFETCH_EN
        // last word has no successor; prefetch does not wrap
        if (rd_rom_q) begin
          if (rd_idx_q != '1) begin
            ce         = 1'b1;
            rom_addr   = rd_idx_q + ADDR_BITS'(1);
            pf_idx_d   = rd_idx_q + ADDR_BITS'(1);
            pf_valid_d = 1'b1;
          end else begin
            pf_valid_d = 1'b0;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rdt_q   <= '0;
`ifdef ROM_WB_FETCH_PREFETCH_EN
      pf_idx_q   <= '0;
      pf_valid_q <= 1'b0;
      rd_idx_q   <= '0;
      rd_rom_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rdt_q   <= rdt_d;
`ifdef ROM_WB_FETCH_PREFETCH_EN
      pf_idx_q   <= pf_idx_d;
      pf_valid_q <= pf_valid_d;
      rd_idx_q   <= rd_idx_d;
      rd_rom_q   <= rd_rom_d;
`endif
    end
  end

  assign wb_ack = (state_q == ACK);
  assign wb_rdt = rdt_q;
  assign rom_ce = ce & ~rst;

endmodule
